spike_dispatcher: RTL and testbench

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

---
 rtl/spike_dispatcher_if.sv | 36 +++
 rtl/spike_dispatcher.sv | 134 +++++++++++++
 tb/tb_spike_dispatcher.sv | 565 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_dispatcher_if.sv
// Bundle connecting the spike dispatcher to its spike FIFO, weight memory,
// synapse accumulator and timestep controller.
interface spike_dispatcher_if #(
  parameter int ADDR_W   = 14,
  parameter int POST_N   = 256,
  parameter int WEIGHT_W = 8
);
  localparam int POST_W = $clog2(POST_N);

  logic                       i_fifo_valid;
  logic [ADDR_W-1:0]          i_fifo_rdata;
  logic                       o_fifo_rd_en;
  logic                       o_wmem_en;
  logic [ADDR_W+POST_W-1:0]   o_wmem_addr;
  logic [WEIGHT_W-1:0]        i_wmem_rdata;
  logic                       o_syn_valid;
  logic [POST_W-1:0]          o_syn_post;
  logic [WEIGHT_W-1:0]        o_syn_weight;
  logic                       i_syn_ready;
  logic                       i_step_end;
  logic                       o_step_done;
  logic                       o_busy;
  logic [15:0]                o_spike_cnt;

  modport slave (
    input  i_fifo_valid, i_fifo_rdata, i_wmem_rdata, i_syn_ready, i_step_end,
    output o_fifo_rd_en, o_wmem_en, o_wmem_addr, o_syn_valid, o_syn_post,
           o_syn_weight, o_step_done, o_busy, o_spike_cnt
  );

  modport master (
    output i_fifo_valid, i_fifo_rdata, i_wmem_rdata, i_syn_ready, i_step_end,
    input  o_fifo_rd_en, o_wmem_en, o_wmem_addr, o_syn_valid, o_syn_post,
           o_syn_weight, o_step_done, o_busy, o_spike_cnt
  );
endinterface

// File: rtl/spike_dispatcher.sv
// Expands each pre-synaptic spike into POST_N weight reads and forwards the
// non-zero weights to the accumulator through a credit-limited 2-entry buffer.
module spike_dispatcher #(
  parameter int ADDR_W   = 14,
  parameter int POST_N   = 256,
  parameter int WEIGHT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spike_dispatcher_if.slave bus
);
  localparam int POST_W = $clog2(POST_N);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pre_addr;
  logic [POST_W-1:0]   post_idx;
  logic                vld_p1;
  logic [POST_W-1:0]   post_p1;
  logic                out_vld;
  logic [POST_W-1:0]   out_post;
  logic [WEIGHT_W-1:0] out_weight;
  logic                skid_vld;
  logic [POST_W-1:0]   skid_post;
  logic [WEIGHT_W-1:0] skid_weight;
  logic                pending;
  logic                step_done;
  logic [15:0]         spike_cnt;

  logic                out_pop;
  logic [1:0]          committed;
  logic                credit_ok;
  logic                issue;
  logic                pop;
  logic                wr;
  logic                drain_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Entries already owed to the buffer: stored ones plus the read in flight.
  assign out_pop   = out_vld & bus.i_syn_ready;
  assign committed = 2'(out_vld) + 2'(skid_vld) + 2'(vld_p1);
  assign credit_ok = (committed - 2'(out_pop)) < 2'd2;
  assign issue     = (state == ISSUE) && credit_ok;
  assign pop       = rst_n && (state == IDLE) && bus.i_fifo_valid && !step_done;
  assign wr        = vld_p1 && (bus.i_wmem_rdata != '0);
  assign drain_ok  = pending && (state == IDLE) && !bus.i_fifo_valid &&
                     !out_vld && !skid_vld && !vld_p1;

  assign bus.o_fifo_rd_en = pop;
  assign bus.o_wmem_en    = issue;
  assign bus.o_wmem_addr  = {pre_addr, post_idx};
  assign bus.o_syn_valid  = out_vld;
  assign bus.o_syn_post   = out_post;
  assign bus.o_syn_weight = out_weight;
  assign bus.o_step_done  = step_done;
  assign bus.o_busy       = (state != IDLE) || out_vld || skid_vld || vld_p1;
  assign bus.o_spike_cnt  = spike_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pre_addr    <= '0;
      post_idx    <= '0;
      vld_p1      <= 1'b0;
      post_p1     <= '0;
      out_vld     <= 1'b0;
      out_post    <= '0;
      out_weight  <= '0;
      skid_vld    <= 1'b0;
      skid_post   <= '0;
      skid_weight <= '0;
      pending     <= 1'b0;
      step_done   <= 1'b0;
      spike_cnt   <= '0;
    end else begin
      // p0: spike fetch and read-address issue
      case (state)
        IDLE: if (pop) begin
          pre_addr <= bus.i_fifo_rdata;
          post_idx <= '0;
          state    <= ISSUE;
        end
        ISSUE: if (issue) begin
          post_idx <= post_idx + 1'b1;
          if (&post_idx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // p1: weight read in flight
      vld_p1  <= issue;
      post_p1 <= post_idx;

      // p2: in-order output register with skid behind it; zero weights vanish
      if (out_pop) begin
        if (skid_vld) begin
          out_post    <= skid_post;
          out_weight  <= skid_weight;
          skid_vld    <= wr;
          if (wr) begin
            skid_post   <= post_p1;
            skid_weight <= bus.i_wmem_rdata;
          end
        end else begin
          out_vld <= wr;
          if (wr) begin
            out_post   <= post_p1;
            out_weight <= bus.i_wmem_rdata;
          end
        end
      end else if (wr) begin
        if (!out_vld) begin
          out_vld    <= 1'b1;
          out_post   <= post_p1;
          out_weight <= bus.i_wmem_rdata;
        end else begin
          skid_vld    <= 1'b1;
          skid_post   <= post_p1;
          skid_weight <= bus.i_wmem_rdata;
        end
      end

      // Timestep bookkeeping: a new step_end always re-arms the request.
      pending   <= bus.i_step_end | (pending & ~drain_ok);
      step_done <= drain_ok;
      if (drain_ok)  spike_cnt <= '0;
      else if (pop)  spike_cnt <= sat_inc(spike_cnt);
    end
  end
endmodule

// File: tb/tb_spike_dispatcher.sv
// Randomized self-checking bench for spike_dispatcher against a queue-based model.
module tb_spike_dispatcher;
  localparam int ADDR_W   = 14;
  localparam int POST_N   = 4;
  localparam int WEIGHT_W = 8;
  localparam int POST_W   = 2;

  typedef struct {
    int cyc;
    int post;
    int weight;
  } syn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_dispatcher_if #(.ADDR_W(ADDR_W), .POST_N(POST_N), .WEIGHT_W(WEIGHT_W)) bus();

  spike_dispatcher #(.ADDR_W(ADDR_W), .POST_N(POST_N), .WEIGHT_W(WEIGHT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit [7:0]          wmem [0:65535];
  logic [ADDR_W-1:0] spk_q [$];
  int                spk_head = 0;
  int                pops_total = 0;
  int                pops_done = 0;

  syn_t syn_log [$];
  syn_t exp_q [$];
  int   pop_log [$];
  int   rd_cyc [$];
  int   rd_addr [$];
  int   done_log [$];
  int   done_cnt_before [$];
  int   done_cnt_at [$];
  int   prev_cnt = 0;
  logic mem_en_s = 1'b0;
  logic [ADDR_W+POST_W-1:0] mem_addr_s = '0;

  always @(posedge clk) cyc++;

  // FWFT spike FIFO: head advances one cycle after a pop is observed.
  always @(posedge clk) begin
    #1;
    while (pops_done < pops_total) begin
      spk_head++;
      pops_done++;
    end
    bus.i_fifo_valid = (spk_head < spk_q.size());
    bus.i_fifo_rdata = (spk_head < spk_q.size()) ? spk_q[spk_head] : '0;
  end

  // Weight memory with one cycle of read latency.
  always @(posedge clk) if (mem_en_s) bus.i_wmem_rdata <= wmem[mem_addr_s];

  always @(negedge clk) begin
    syn_t e;
    mem_en_s   = bus.o_wmem_en;
    mem_addr_s = bus.o_wmem_addr;
    if (bus.o_fifo_rd_en) begin
      pops_total++;
      pop_log.push_back(cyc);
    end
    if (bus.o_wmem_en) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(int'(bus.o_wmem_addr));
    end
    if (bus.o_syn_valid && bus.i_syn_ready) begin
      e.cyc = cyc;
      e.post = int'(bus.o_syn_post);
      e.weight = int'(bus.o_syn_weight);
      syn_log.push_back(e);
    end
    if (bus.o_step_done) begin
      done_log.push_back(cyc);
      done_cnt_before.push_back(prev_cnt);
      done_cnt_at.push_back(int'(bus.o_spike_cnt));
    end
    prev_cnt = int'(bus.o_spike_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic void build_model(input logic [ADDR_W-1:0] a);
    syn_t e;
    for (int i = 0; i < POST_N; i++) begin
      e.cyc = 0;
      e.post = i;
      e.weight = int'(wmem[{a, POST_W'(i)}]);
      if (e.weight != 0) exp_q.push_back(e);
    end
  endfunction

  task automatic wait_quiet(input int max_cyc, input bit rand_ready, output bit to);
    to = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (rand_ready) bus.i_syn_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!bus.o_busy && !bus.o_fifo_rd_en && pops_total == spk_q.size()) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_step_end = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bit to;
    int sb = syn_log.size();
    exp_q.delete();
    bus.i_syn_ready = 1'b1;
    for (int i = 0; i < POST_N; i++) wmem[{14'h0ABC, POST_W'(i)}] = 8'(i + 1);
    build_model(14'h0ABC);
    spk_q.push_back(14'h0ABC);
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.o_fifo_rd_en, bus.o_wmem_en, bus.o_syn_valid, bus.o_step_done, bus.o_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.o_fifo_rd_en, bus.o_wmem_en, bus.o_syn_valid, bus.o_step_done, bus.o_busy});
    end
    n_checks++;
    if (bus.o_syn_post !== '0 || bus.o_syn_weight !== '0 || bus.o_spike_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: got post=%0d w=%0d cnt=%0d expected 0 0 0",
               bus.o_syn_post, bus.o_syn_weight, bus.o_spike_cnt);
    end
    tick();
    rst_n = 1'b1;
    wait_quiet(60, 1'b0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL reset_release_timeout: got busy expected idle"); end
    n_checks++;
    if (syn_log.size() - sb != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_release_count: got %0d expected %0d", syn_log.size() - sb, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (syn_log[sb+i].post != exp_q[i].post || syn_log[sb+i].weight != exp_q[i].weight) begin
          n_fail++;
          $display("FAIL reset_release_entry%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, exp_q[i].post, exp_q[i].weight);
        end
      end
    end
    n_checks++;
    if (bus.o_spike_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_release_cnt: got %0d expected 1", bus.o_spike_cnt);
    end
  endtask

  task automatic test_basic();
    bit to;
    int t;
    int pb, rb, sb;
    do_reset();
    bus.i_syn_ready = 1'b1;
    for (int i = 0; i < POST_N; i++) wmem[{14'h0123, POST_W'(i)}] = 8'(5 + i);
    pb = pop_log.size(); rb = rd_cyc.size(); sb = syn_log.size();
    spk_q.push_back(14'h0123);
    wait_quiet(60, 1'b0, to);
    n_checks++;
    if (to || pop_log.size() - pb != 1 || rd_cyc.size() - rb != POST_N || syn_log.size() - sb != POST_N) begin
      n_fail++;
      $display("FAIL basic_counts: got to=%0d pops=%0d reads=%0d syn=%0d expected 0 1 4 4", to,
               pop_log.size() - pb, rd_cyc.size() - rb, syn_log.size() - sb);
    end else begin
      t = pop_log[pb];
      for (int i = 0; i < POST_N; i++) begin
        n_checks++;
        if (rd_addr[rb+i] != ((32'h123 << POST_W) | i) || rd_cyc[rb+i] != t + 1 + i) begin
          n_fail++;
          $display("FAIL basic_read%0d: got addr=%0h cyc=%0d expected addr=%0h cyc=%0d", i,
                   rd_addr[rb+i], rd_cyc[rb+i], (32'h123 << POST_W) | i, t + 1 + i);
        end
        n_checks++;
        if (syn_log[sb+i].post != i || syn_log[sb+i].weight != 5 + i || syn_log[sb+i].cyc != t + 3 + i) begin
          n_fail++;
          $display("FAIL basic_syn%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, syn_log[sb+i].cyc, i, 5 + i, t + 3 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit seen = 1'b0;
    int ref_post = 0, ref_w = 0;
    int rb, sb, k;
    do_reset();
    exp_q.delete();
    bus.i_syn_ready = 1'b0;
    build_model(14'h0123);
    rb = rd_cyc.size(); sb = syn_log.size();
    spk_q.push_back(14'h0123);
    k = 0;
    while (pops_total != spk_q.size() && k < 20) begin
      tick();
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 20) begin n_fail++; $display("FAIL bp_pop_timeout: got no pop expected pop"); end
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      if (seen) begin
        n_checks++;
        if (bus.o_syn_valid !== 1'b1 || int'(bus.o_syn_post) != ref_post || int'(bus.o_syn_weight) != ref_w) begin
          n_fail++;
          $display("FAIL bp_hold: got v=%0d (%0d,%0d) expected v=1 (%0d,%0d)", bus.o_syn_valid,
                   bus.o_syn_post, bus.o_syn_weight, ref_post, ref_w);
        end
      end else if (bus.o_syn_valid === 1'b1) begin
        seen = 1'b1;
        ref_post = int'(bus.o_syn_post);
        ref_w = int'(bus.o_syn_weight);
      end
    end
    n_checks++;
    if (rd_cyc.size() - rb != 2) begin
      n_fail++;
      $display("FAIL bp_stall_reads: got %0d expected 2", rd_cyc.size() - rb);
    end
    bus.i_syn_ready = 1'b1;
    wait_quiet(60, 1'b0, to);
    n_checks++;
    if (to || rd_cyc.size() - rb != POST_N || syn_log.size() - sb != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_drain: got to=%0d reads=%0d syn=%0d expected 0 %0d %0d", to,
               rd_cyc.size() - rb, syn_log.size() - sb, POST_N, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (syn_log[sb+i].post != exp_q[i].post || syn_log[sb+i].weight != exp_q[i].weight) begin
          n_fail++;
          $display("FAIL bp_entry%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, exp_q[i].post, exp_q[i].weight);
        end
      end
    end
  endtask

  task automatic test_zero_weights();
    bit to;
    int rb, sb;
    int wv [4] = '{0, 9, 0, 3};
    do_reset();
    exp_q.delete();
    bus.i_syn_ready = 1'b1;
    for (int i = 0; i < POST_N; i++) wmem[{14'h0456, POST_W'(i)}] = 8'(wv[i]);
    build_model(14'h0456);
    rb = rd_cyc.size(); sb = syn_log.size();
    spk_q.push_back(14'h0456);
    wait_quiet(60, 1'b0, to);
    n_checks++;
    if (to || rd_cyc.size() - rb != POST_N || syn_log.size() - sb != 2) begin
      n_fail++;
      $display("FAIL zero_counts: got to=%0d reads=%0d syn=%0d expected 0 4 2", to,
               rd_cyc.size() - rb, syn_log.size() - sb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (syn_log[sb+i].post != exp_q[i].post || syn_log[sb+i].weight != exp_q[i].weight) begin
          n_fail++;
          $display("FAIL zero_entry%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, exp_q[i].post, exp_q[i].weight);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int pb, sb;
    logic [ADDR_W-1:0] a [3];
    do_reset();
    exp_q.delete();
    bus.i_syn_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a[k] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      for (int i = 0; i < POST_N; i++) wmem[{a[k], POST_W'(i)}] = 8'($urandom_range(1, 255));
    end
    for (int k = 0; k < 3; k++) build_model(a[k]);
    pb = pop_log.size(); sb = syn_log.size();
    for (int k = 0; k < 3; k++) spk_q.push_back(a[k]);
    wait_quiet(100, 1'b0, to);
    n_checks++;
    if (to || pop_log.size() - pb != 3 || syn_log.size() - sb != 3 * POST_N) begin
      n_fail++;
      $display("FAIL b2b_counts: got to=%0d pops=%0d syn=%0d expected 0 3 %0d", to,
               pop_log.size() - pb, syn_log.size() - sb, 3 * POST_N);
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (pop_log[pb+k+1] != pop_log[pb+k] + POST_N + 1) begin
          n_fail++;
          $display("FAIL b2b_pop_gap%0d: got %0d expected %0d", k, pop_log[pb+k+1], pop_log[pb+k] + POST_N + 1);
        end
      end
      for (int j = 0; j < 3 * POST_N; j++) begin
        n_checks++;
        if (syn_log[sb+j].post != exp_q[j].post || syn_log[sb+j].weight != exp_q[j].weight ||
            syn_log[sb+j].cyc != pop_log[pb + j / POST_N] + 3 + (j % POST_N)) begin
          n_fail++;
          $display("FAIL b2b_entry%0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", j,
                   syn_log[sb+j].post, syn_log[sb+j].weight, syn_log[sb+j].cyc, exp_q[j].post,
                   exp_q[j].weight, pop_log[pb + j / POST_N] + 3 + (j % POST_N));
        end
      end
    end
  endtask

  task automatic test_step();
    bit to;
    int db, sb;
    logic [ADDR_W-1:0] a [3];
    do_reset();
    exp_q.delete();
    bus.i_syn_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a[k] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      for (int i = 0; i < POST_N; i++)
        wmem[{a[k], POST_W'(i)}] = (i != POST_N - 1 && $urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    end
    for (int k = 0; k < 3; k++) build_model(a[k]);
    db = done_log.size(); sb = syn_log.size();
    for (int k = 0; k < 3; k++) spk_q.push_back(a[k]);
    tick();
    bus.i_step_end = 1'b1;
    tick();
    bus.i_step_end = 1'b0;
    wait_quiet(300, 1'b1, to);
    bus.i_syn_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    n_checks++;
    if (to || done_log.size() - db != 1 || syn_log.size() - sb != exp_q.size()) begin
      n_fail++;
      $display("FAIL step_counts: got to=%0d dones=%0d syn=%0d expected 0 1 %0d", to,
               done_log.size() - db, syn_log.size() - sb, exp_q.size());
    end else begin
      n_checks++;
      if (done_log[db] <= syn_log[syn_log.size()-1].cyc) begin
        n_fail++;
        $display("FAIL step_done_order: got done@%0d expected after %0d", done_log[db], syn_log[syn_log.size()-1].cyc);
      end
      n_checks++;
      if (done_cnt_before[db] != 3 || done_cnt_at[db] != 0) begin
        n_fail++;
        $display("FAIL step_cnt: got before=%0d at=%0d expected 3 0", done_cnt_before[db], done_cnt_at[db]);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (syn_log[sb+i].post != exp_q[i].post || syn_log[sb+i].weight != exp_q[i].weight) begin
          n_fail++;
          $display("FAIL step_entry%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, exp_q[i].post, exp_q[i].weight);
        end
      end
    end
  endtask

  task automatic test_rearm_priority();
    bit to;
    int s, db, pb;
    do_reset();
    bus.i_syn_ready = 1'b1;
    for (int i = 0; i < POST_N; i++) wmem[{14'h0777, POST_W'(i)}] = 8'($urandom_range(1, 255));
    db = done_log.size(); pb = pop_log.size();
    tick();
    s = cyc;
    bus.i_step_end = 1'b1;
    tick();
    bus.i_step_end = 1'b0;
    spk_q.push_back(14'h0777);
    tick();
    bus.i_step_end = 1'b1;
    tick();
    bus.i_step_end = 1'b0;
    wait_quiet(60, 1'b0, to);
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    n_checks++;
    if (to || done_log.size() - db != 2 || pop_log.size() - pb != 1) begin
      n_fail++;
      $display("FAIL rearm_counts: got to=%0d dones=%0d pops=%0d expected 0 2 1", to,
               done_log.size() - db, pop_log.size() - pb);
    end else begin
      n_checks++;
      if (done_log[db] != s + 2) begin
        n_fail++;
        $display("FAIL rearm_first_done: got cyc %0d expected %0d", done_log[db], s + 2);
      end
      n_checks++;
      if (pop_log[pb] != s + 3) begin
        n_fail++;
        $display("FAIL done_priority_pop: got cyc %0d expected %0d", pop_log[pb], s + 3);
      end
      n_checks++;
      if (done_cnt_before[db+1] != 1 || done_cnt_at[db+1] != 0) begin
        n_fail++;
        $display("FAIL rearm_second_cnt: got before=%0d at=%0d expected 1 0", done_cnt_before[db+1], done_cnt_at[db+1]);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    bit to;
    int k, rb, sb;
    do_reset();
    exp_q.delete();
    bus.i_syn_ready = 1'b1;
    for (int i = 0; i < POST_N; i++) wmem[{14'h0321, POST_W'(i)}] = 8'(11 + i);
    for (int i = 0; i < POST_N; i++) wmem[{14'h0654, POST_W'(i)}] = 8'(21 + i);
    build_model(14'h0654);
    rb = rd_cyc.size();
    spk_q.push_back(14'h0321);
    k = 0;
    while (pops_total != spk_q.size() && k < 20) begin
      tick();
      @(negedge clk);
      k++;
    end
    tick();
    tick();
    n_checks++;
    if (k >= 20 || rd_cyc.size() - rb != 2) begin
      n_fail++;
      $display("FAIL midreset_setup: got reads=%0d expected 2", rd_cyc.size() - rb);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_fifo_rd_en, bus.o_wmem_en, bus.o_syn_valid, bus.o_step_done, bus.o_busy} !== 5'b0 ||
        bus.o_syn_post !== '0 || bus.o_syn_weight !== '0 || bus.o_spike_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ctrl=%b post=%0d w=%0d cnt=%0d expected all 0",
               {bus.o_fifo_rd_en, bus.o_wmem_en, bus.o_syn_valid, bus.o_step_done, bus.o_busy},
               bus.o_syn_post, bus.o_syn_weight, bus.o_spike_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rb = rd_cyc.size(); sb = syn_log.size();
    spk_q.push_back(14'h0654);
    wait_quiet(60, 1'b0, to);
    n_checks++;
    if (to || rd_cyc.size() - rb != POST_N || syn_log.size() - sb != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_counts: got to=%0d reads=%0d syn=%0d expected 0 4 %0d", to,
               rd_cyc.size() - rb, syn_log.size() - sb, exp_q.size());
    end else begin
      n_checks++;
      if (rd_addr[rb] != (32'h654 << POST_W)) begin
        n_fail++;
        $display("FAIL midreset_first_read: got %0h expected %0h", rd_addr[rb], 32'h654 << POST_W);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (syn_log[sb+i].post != exp_q[i].post || syn_log[sb+i].weight != exp_q[i].weight) begin
          n_fail++;
          $display("FAIL midreset_entry%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, exp_q[i].post, exp_q[i].weight);
        end
      end
      n_checks++;
      if (bus.o_spike_cnt !== 16'd1) begin
        n_fail++;
        $display("FAIL midreset_cnt: got %0d expected 1", bus.o_spike_cnt);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int sb, pushed, c;
    logic [ADDR_W-1:0] a [6];
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      a[k] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      for (int i = 0; i < POST_N; i++)
        wmem[{a[k], POST_W'(i)}] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    end
    for (int k = 0; k < 6; k++) build_model(a[k]);
    sb = syn_log.size();
    pushed = 0;
    c = 0;
    while (pushed < 6 && c < 500) begin
      tick();
      bus.i_syn_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        spk_q.push_back(a[pushed]);
        pushed++;
      end
      c++;
    end
    wait_quiet(1000, 1'b1, to);
    bus.i_syn_ready = 1'b1;
    n_checks++;
    if (to || syn_log.size() - sb != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_counts: got to=%0d syn=%0d expected 0 %0d", to, syn_log.size() - sb, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (syn_log[sb+i].post != exp_q[i].post || syn_log[sb+i].weight != exp_q[i].weight) begin
          n_fail++;
          $display("FAIL random_entry%0d: got (%0d,%0d) expected (%0d,%0d)", i,
                   syn_log[sb+i].post, syn_log[sb+i].weight, exp_q[i].post, exp_q[i].weight);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_syn_ready = 1'b0;
    bus.i_step_end = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_weights();
    test_back_to_back();
    test_step();
    test_rearm_priority();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1);
  end
endmodule
